// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and types for the 4-digit 7-segment scan driver.
// Segment patterns are active-low in bit order [6:0] = g..a (bit 0 = a).
package fnd_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam logic [6:0] SEG_DASH   = 7'h3F;

   // BCD glyphs, active-low, decimal point excluded
   localparam logic [6:0] SEG_DIG0 = 7'h40;
   localparam logic [6:0] SEG_DIG1 = 7'h79;
   localparam logic [6:0] SEG_DIG2 = 7'h24;
   localparam logic [6:0] SEG_DIG3 = 7'h30;
   localparam logic [6:0] SEG_DIG4 = 7'h19;
   localparam logic [6:0] SEG_DIG5 = 7'h12;
   localparam logic [6:0] SEG_DIG6 = 7'h02;
   localparam logic [6:0] SEG_DIG7 = 7'h78;
   localparam logic [6:0] SEG_DIG8 = 7'h00;
   localparam logic [6:0] SEG_DIG9 = 7'h10;

   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t LAST_DIGIT = 2'd3;

   // Extract the BCD nibble of the given digit position from a 4-digit word.
   function automatic logic [3:0] digit_of(input logic [15:0] word, input digit_idx_t idx);
      logic [3:0] nib;
      nib = 4'h0;
      case (idx)
         2'd0:    nib = word[3:0];
         2'd1:    nib = word[7:4];
         2'd2:    nib = word[11:8];
         2'd3:    nib = word[15:12];
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/fnd_decoder_7seg.sv
// fnd_decoder_7seg: combinational BCD to active-low 7-segment decoder.
// Codes A-F are not valid BCD and are rendered as a dash.
module fnd_decoder_7seg
   import fnd_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_n_o
);

   // Map each BCD code to its glyph; anything else shows a dash
   always_comb begin
      seg_n_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_n_o = SEG_DIG0;
         4'd1:    seg_n_o = SEG_DIG1;
         4'd2:    seg_n_o = SEG_DIG2;
         4'd3:    seg_n_o = SEG_DIG3;
         4'd4:    seg_n_o = SEG_DIG4;
         4'd5:    seg_n_o = SEG_DIG5;
         4'd6:    seg_n_o = SEG_DIG6;
         4'd7:    seg_n_o = SEG_DIG7;
         4'd8:    seg_n_o = SEG_DIG8;
         4'd9:    seg_n_o = SEG_DIG9;
         default: seg_n_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. A shadow register accepts new values at any time; the
// visible copy is only refreshed when the scan wraps from digit3 to digit0,
// so a frame never mixes two values. Blink and decimal-point masks are live.
// Optional build macro FND_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit0 is always shown).
module fnd_scan_driver
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic [15:0] value,
   input  logic        value_valid,
   input  logic [3:0]  blink_mask,
   input  logic [3:0]  dp_mask,
   input  logic        enable,
   output logic [3:0]  com,
   output logic [7:0]  seg_7,
   output logic        frame_done
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
   digit_idx_t         digit_idx_q,   digit_idx_d;
   logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic               blink_phase_q, blink_phase_d;
   logic [15:0]        shadow_q,      shadow_d;
   logic [15:0]        display_q,     display_d;
   logic [3:0]         com_q,         com_d;
   logic [7:0]         seg_q,         seg_d;
   logic               frame_done_q,  frame_done_d;

   logic               scan_tc_s;
   logic               wrap_s;
   logic               blink_tc_s;
   logic [3:0]         cur_digit_s;
   logic [6:0]         dec_seg_s;
   logic               lz_blank_s;

   fnd_decoder_7seg u_decoder (
      .bcd_i   (cur_digit_s),
      .seg_n_o (dec_seg_s)
   );

   // Scan/blink timing and double-buffered value capture
   always_comb begin
      scan_tc_s     = (scan_cnt_q == SCAN_LAST);
      wrap_s        = scan_tc_s && (digit_idx_q == LAST_DIGIT);
      blink_tc_s    = (blink_cnt_q == BLINK_LAST);

      scan_cnt_d    = scan_tc_s  ? '0 : scan_cnt_q  + SCAN_W'(1);
      digit_idx_d   = scan_tc_s  ? digit_idx_q + 2'd1 : digit_idx_q;
      blink_cnt_d   = blink_tc_s ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_tc_s ? ~blink_phase_q : blink_phase_q;

      // display samples the shadow before any same-cycle capture lands
      display_d     = wrap_s      ? shadow_q : display_q;
      shadow_d      = value_valid ? value    : shadow_q;
      frame_done_d  = wrap_s;
   end

   // Leading-zero detection: this digit and every higher one are zero
   always_comb begin
      lz_blank_s = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
      case (digit_idx_q)
         2'd0:    lz_blank_s = 1'b0;
         2'd1:    lz_blank_s = (display_q[15:4]  == 12'h000);
         2'd2:    lz_blank_s = (display_q[15:8]  == 8'h00);
         2'd3:    lz_blank_s = (display_q[15:12] == 4'h0);
         default: lz_blank_s = 1'b0;
      endcase
`else
      lz_blank_s = 1'b0;
`endif
   end

   // Anode and segment pattern for the digit currently being scanned
   always_comb begin
      cur_digit_s = digit_of(display_q, digit_idx_q);
      com_d       = 4'b1111;
      seg_d       = SEG_BLANK;
      if (enable) begin
         com_d = ~(4'b0001 << digit_idx_q);
         if (blink_phase_q && blink_mask[digit_idx_q]) begin
            seg_d = SEG_BLANK;
         end else if (lz_blank_s) begin
            seg_d = {~dp_mask[digit_idx_q], SEG_OFF};
         end else begin
            seg_d = {~dp_mask[digit_idx_q], dec_seg_s};
         end
      end else begin
         com_d = 4'b1111;
         seg_d = SEG_BLANK;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset_p) begin
         scan_cnt_q    <= '0;
         digit_idx_q   <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         shadow_q      <= 16'h0000;
         display_q     <= 16'h0000;
         com_q         <= 4'b1111;
         seg_q         <= SEG_BLANK;
         frame_done_q  <= 1'b0;
      end else begin
         scan_cnt_q    <= scan_cnt_d;
         digit_idx_q   <= digit_idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         shadow_q      <= shadow_d;
         display_q     <= display_d;
         com_q         <= com_d;
         seg_q         <= seg_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign com        = com_q;
   assign seg_7      = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: scoreboard bench for fnd_scan_driver (SCAN_DIV=4,
// BLINK_DIV=64). A cycle-count reference model pushes the expected
// {com, seg_7, frame_done} on every clock; a monitor pops and compares on
// the falling edge. Directed slot checks add fixed expectations on top.
module tb_fnd_scan_driver;

   localparam int SCAN  = 4;
   localparam int BLINK = 64;
   localparam int FRAME = 4 * SCAN;

   logic        clk = 1'b0;
   logic        reset_p;
   logic [15:0] value;
   logic        value_valid;
   logic [3:0]  blink_mask;
   logic [3:0]  dp_mask;
   logic        enable;
   logic [3:0]  com;
   logic [7:0]  seg_7;
   logic        frame_done;

   int          checks = 0;
   int          errors = 0;
   logic [12:0] exp_q[$];

   int          m_k;
   logic [15:0] m_shadow;
   logic [15:0] m_display;

   fnd_scan_driver #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .value       (value),
      .value_valid (value_valid),
      .blink_mask  (blink_mask),
      .dp_mask     (dp_mask),
      .enable      (enable),
      .com         (com),
      .seg_7       (seg_7),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // Reference glyph table (full byte, dp off)
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0: g = 8'hC0;  4'd1: g = 8'hF9;  4'd2: g = 8'hA4;  4'd3: g = 8'hB0;
         4'd4: g = 8'h99;  4'd5: g = 8'h92;  4'd6: g = 8'h82;  4'd7: g = 8'hF8;
         4'd8: g = 8'h80;  4'd9: g = 8'h90;  default: g = 8'hBF;
      endcase
      return g[6:0];
   endfunction

   // Reference model: everything derived from the edge count since reset
   initial begin : model
      int          slot;
      int          ph;
      logic [3:0]  d;
      logic [3:0]  c;
      logic [7:0]  s;
      logic        fd;
      logic        lz;
      m_k = 0; m_shadow = 16'h0; m_display = 16'h0;
      forever begin
         @(posedge clk);
         if (reset_p) begin
            m_k = 0; m_shadow = 16'h0; m_display = 16'h0;
            exp_q.push_back({4'b1111, 8'hFF, 1'b0});
         end else begin
            m_k++;
            slot = ((m_k - 1) / SCAN) % 4;
            ph   = ((m_k - 1) / BLINK) % 2;
            d    = m_display[4*slot +: 4];
`ifdef FND_LEADING_ZERO_BLANK_EN
            lz   = (slot != 0) && ((m_display >> (4*slot)) == 16'h0);
`else
            lz   = 1'b0;
`endif
            if (!enable) begin
               c = 4'b1111; s = 8'hFF;
            end else begin
               c = ~(4'b0001 << slot);
               if (ph == 1 && blink_mask[slot]) s = 8'hFF;
               else s = {~dp_mask[slot], lz ? 7'h7F : glyph(d)};
            end
            fd = ((m_k % FRAME) == 0);
            exp_q.push_back({c, s, fd});
            if (fd) m_display = m_shadow;
            if (value_valid) m_shadow = value;
         end
      end
   end

   // Monitor: pop one expectation per clock and compare
   initial begin : monitor
      logic [12:0] e;
      logic [12:0] a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {com, seg_7, frame_done};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL scoreboard t=%0t com/seg/fd got %b/%h/%b expected %b/%h/%b",
                        $time, a[12:9], a[8:1], a[0], e[12:9], e[8:1], e[0]);
            end
         end
      end
   end

   task automatic wait_fd();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 3 * FRAME);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_timeout got %b expected 1 within %0d cycles", frame_done, 3 * FRAME);
      end
   endtask

   // Called right after a frame_done falling-edge sample: checks one full frame
   task automatic check_slots(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] exp_seg [4];
      logic [3:0] exp_com;
      exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
      for (int sl = 0; sl < 4; sl++) begin
         for (int c = 0; c < SCAN; c++) begin
            @(negedge clk);
            exp_com = ~(4'b0001 << sl);
            checks++;
            if (com !== exp_com || seg_7 !== exp_seg[sl]) begin
               errors++;
               $display("FAIL slot%0d com/seg got %b/%h expected %b/%h", sl, com, seg_7, exp_com, exp_seg[sl]);
            end
         end
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_period frame_done got %b expected 1", frame_done);
      end
   endtask

   task automatic load(input logic [15:0] v);
      value = v; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0; value = 16'($urandom);
   endtask

   initial begin : stimulus
      int rst_at;
      int n;
      reset_p = 1'b1; value = 16'hBEEF; value_valid = 1'b1;
      blink_mask = 4'hF; dp_mask = 4'hF; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         value = 16'($urandom); value_valid = 1'($urandom);
         blink_mask = 4'($urandom); dp_mask = 4'($urandom); enable = 1'($urandom);
      end
      value_valid = 1'b0; blink_mask = 4'h0; dp_mask = 4'h0; enable = 1'b1;
      reset_p = 1'b0;

      // basic display
      wait_fd();
      load(16'h1234);
      wait_fd();
      check_slots(8'h99, 8'hB0, 8'hA4, 8'hF9);

      // blink + decimal point over several blink half-periods
      blink_mask = 4'b0011; dp_mask = 4'b0100;
      repeat (4 * BLINK) @(negedge clk);
      blink_mask = 4'h0; dp_mask = 4'h0;

      // non-BCD digit, then display disabled
      wait_fd();
      load(16'h00A0);
      wait_fd();
`ifdef FND_LEADING_ZERO_BLANK_EN
      check_slots(8'hC0, 8'hBF, 8'hFF, 8'hFF);
`else
      check_slots(8'hC0, 8'hBF, 8'hC0, 8'hC0);
`endif
      enable = 1'b0;
      repeat (3 * FRAME) @(negedge clk);
      enable = 1'b1;

      // capture coinciding with the wrap: old value for one more frame
      wait_fd();
      load(16'h1234);
      wait_fd();
      repeat (FRAME - 1) @(negedge clk);
      load(16'h9999);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL coherency_align frame_done got %b expected 1", frame_done);
      end
      check_slots(8'h99, 8'hB0, 8'hA4, 8'hF9);
      check_slots(8'h90, 8'h90, 8'h90, 8'h90);

      // leading zeros
      wait_fd();
      load(16'h0050);
      wait_fd();
`ifdef FND_LEADING_ZERO_BLANK_EN
      check_slots(8'hC0, 8'h92, 8'hFF, 8'hFF);
`else
      check_slots(8'hC0, 8'h92, 8'hC0, 8'hC0);
`endif
      load(16'h0000);
      wait_fd();
`ifdef FND_LEADING_ZERO_BLANK_EN
      check_slots(8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
      check_slots(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

      // randomized traffic with one mid-run reset
      rst_at = $urandom_range(200, 500);
      for (int i = 0; i < 800; i++) begin
         value       = 16'($urandom);
         value_valid = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) begin
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
         end
         enable  = ($urandom_range(0, 9) != 0);
         reset_p = (i == rst_at || i == rst_at + 1);
         @(negedge clk);
      end
      reset_p = 1'b0; value_valid = 1'b0;

      // drain the scoreboard
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
